// File: rtl/pulse_measure.sv
// Pulse input synchroniser, edge strobes, and high-time/period measurement with a valid/ready result port.
// Optional glitch filter enabled by defining PULSE_MEASURE_GLITCH_FILTER_EN.
module pulse_measure #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   output logic             rise,
   output logic             fall,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_ovf,
   output logic             drop
);

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
   localparam int FILT_STAGES = 2;
`else
   localparam int FILT_STAGES = 0;
`endif
   // Depth from the input pin to lvl_q; strobes stay off until it holds real samples.
   localparam int PIPE = SYNC_STAGES + 2 + FILT_STAGES;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic [PIPE-1:0]        vld;
   logic                   s, lvl, lvl_q;
   state_t                 state, state_nx;
   logic                   start, complete, cnt_h, cnt_p;
   logic [CNT_W-1:0]       hacc, pacc;
   logic                   ovf;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '0;
         vld  <= '0;
      end else begin
         sync[0] <= in;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         vld <= {vld[PIPE-2:0], 1'b1};
      end
   end

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
   logic h1, h2, s_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h1     <= 1'b0;
         h2     <= 1'b0;
         s_hold <= 1'b0;
      end else begin
         h1     <= sync[SYNC_STAGES-1];
         h2     <= h1;
         s_hold <= s;
      end
   end

   assign s = (sync[SYNC_STAGES-1] == h1 && h1 == h2) ? sync[SYNC_STAGES-1] : s_hold;
`else
   assign s = sync[SYNC_STAGES-1];
`endif

   // A level seen before the pipeline fills (e.g. high through reset) never strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl   <= 1'b0;
         lvl_q <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         lvl   <= s;
         lvl_q <= lvl;
         rise  <= vld[PIPE-1] & lvl & ~lvl_q;
         fall  <= vld[PIPE-1] & ~lvl & lvl_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      complete = 1'b0;
      cnt_h    = 1'b0;
      cnt_p    = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               start    = 1'b1;
               state_nx = HIGH;
            end
         end
         HIGH: begin
            cnt_p = 1'b1;
            if (fall) state_nx = LOW;
            else      cnt_h    = 1'b1;
         end
         LOW: begin
            if (rise) begin
               complete = 1'b1;
               start    = 1'b1;
               state_nx = HIGH;
            end else begin
               cnt_p = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // The strobe cycle itself is the first cycle of the new measurement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hacc <= '0;
         pacc <= '0;
         ovf  <= 1'b0;
      end else if (start) begin
         hacc <= CNT_ONE;
         pacc <= CNT_ONE;
         ovf  <= 1'b0;
      end else begin
         if (cnt_h) begin
            if (hacc == CNT_MAX) ovf  <= 1'b1;
            else                 hacc <= hacc + CNT_ONE;
         end
         if (cnt_p) begin
            if (pacc == CNT_MAX) ovf  <= 1'b1;
            else                 pacc <= pacc + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meas_valid <= 1'b0;
         high_cnt   <= '0;
         period_cnt <= '0;
         meas_ovf   <= 1'b0;
         drop       <= 1'b0;
      end else begin
         drop <= 1'b0;
         if (complete) begin
            if (!meas_valid || meas_ready) begin
               meas_valid <= 1'b1;
               high_cnt   <= hacc;
               period_cnt <= pacc;
               meas_ovf   <= ovf;
            end else begin
               drop <= 1'b1;
            end
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule
